lut_calc_multi: RTL and testbench

LUT_CALC_MULTI -- requirements
Module: lut_calc_multi

---
 rtl/lut_calc_multi_if.sv | 39 +++
 rtl/lut_calc_multi.sv | 159 +++++++++++++++
 tb/tb_lut_calc_multi.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lut_calc_multi_if.sv
// Lookup/load bus for lut_calc_multi: lookup request/response plus table-load handshake.
// Latency: none (wires only).
// Backpressure: load_data is taken only while load_ready is high; lookups are never stalled.
interface lut_calc_multi_if #(
    parameter int NCH = 4,
    parameter int AW  = 13,
    parameter int DW  = 28,
    parameter int OW  = 21
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [AW-1:0]     addr_in;
    logic              addr_valid;
    logic              sat_en;
    logic [NCH*OW-1:0] lut_out;
    logic              out_valid;
    logic              load_start;
    logic [CW-1:0]     load_ch;
    logic [DW-1:0]     load_data;
    logic              load_valid;
    logic              load_ready;
    logic              load_abort;
    logic              load_done;
    logic              busy;

    // Requester side: drives lookups and table loads.
    modport master (
        output addr_in, addr_valid, sat_en,
        output load_start, load_ch, load_data, load_valid, load_abort,
        input  lut_out, out_valid, load_ready, load_done, busy
    );

    // Lookup block side.
    modport slave (
        input  addr_in, addr_valid, sat_en,
        input  load_start, load_ch, load_data, load_valid, load_abort,
        output lut_out, out_valid, load_ready, load_done, busy
    );
endinterface

// File: rtl/lut_calc_multi.sv
// Multi-channel lookup table with shared address, per-channel DW->OW saturate/truncate, and a table-load FSM.
// Latency: lookup sampled at edge N appears at edge N+2, one result per cycle.
// Backpressure: lookups never stall; loads accept a word per cycle while load_ready is high.
module lut_calc_multi #(
    parameter int NCH = 4,
    parameter int AW  = 13,
    parameter int DW  = 28,
    parameter int OW  = 21
) (
    input  logic              clk,
    input  logic              rst,
    lut_calc_multi_if.slave   bus
);
    localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    // Convert one stored word to the output width: clamp when the upper
    // bits are not a pure sign extension, otherwise keep the low OW bits.
    function automatic logic [OW-1:0] word_conv(input logic [DW-1:0] w, input logic sat);
        logic [DW-OW:0] top;
        logic           fits;
        top  = w[DW-1:OW-1];
        fits = (&top) || (~|top);
        if (sat && !fits)
            word_conv = w[DW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
        else
            word_conv = w[OW-1:0];
    endfunction

    // Table storage is never reset; contents survive reset and aborted loads.
    logic [DW-1:0]     mem [NCH][DEPTH];
    logic [DW-1:0]     rd_q [NCH];

    state_t            state_q;
    logic [CW-1:0]     ch_q;
    logic [AW-1:0]     ptr_q;
    logic              load_ready_q;
    logic              load_done_q;
    logic              busy_q;

    logic              v1_q;
    logic              sat1_q;
    logic              v2_q;
    logic [NCH*OW-1:0] cv2_q;
    logic [NCH*OW-1:0] cv2_d;
    logic [NCH*OW-1:0] lut_out_q;
    logic              out_valid_q;

    logic              wr_en;

    // An abort in the same cycle as load_valid suppresses that write.
    assign wr_en = load_ready_q && bus.load_valid && !bus.load_abort;

    // Single write port, steered to the channel latched at load start.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[ch_q][ptr_q] <= bus.load_data;
    end

    // Synchronous read of every channel; a same-cycle write is not visible yet (old data returned).
    always_ff @(posedge clk) begin
        if (bus.addr_valid) begin
            for (int k = 0; k < NCH; k++)
                rd_q[k] <= mem[k][bus.addr_in];
        end
    end

    // Width conversion of the freshly read words, using the sat_en captured with the request.
    always_comb begin
        cv2_d = '0;
        for (int k = 0; k < NCH; k++)
            cv2_d[k*OW +: OW] = word_conv(rd_q[k], sat1_q);
    end

    // Lookup pipeline: valid/sat_en travel with the data; lut_out holds between results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q        <= 1'b0;
            sat1_q      <= 1'b0;
            v2_q        <= 1'b0;
            cv2_q       <= '0;
            lut_out_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            v1_q        <= bus.addr_valid;
            sat1_q      <= bus.sat_en;
            v2_q        <= v1_q;
            if (v1_q)
                cv2_q   <= cv2_d;
            out_valid_q <= v2_q;
            if (v2_q)
                lut_out_q <= cv2_q;
        end
    end

    // Load FSM with registered handshake/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ch_q         <= '0;
            ptr_q        <= '0;
            load_ready_q <= 1'b0;
            load_done_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    load_done_q <= 1'b0;
                    if (bus.load_start) begin
                        state_q      <= LOAD;
                        ch_q         <= bus.load_ch;
                        ptr_q        <= '0;
                        load_ready_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.load_abort) begin
                        state_q      <= IDLE;
                        load_ready_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end else if (bus.load_valid) begin
                        // Pointer wraps naturally to 0 after the last address.
                        ptr_q <= ptr_q + AW'(1);
                        if (ptr_q == {AW{1'b1}}) begin
                            state_q      <= DONE;
                            load_ready_q <= 1'b0;
                            load_done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    load_done_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
                default: begin
                    state_q      <= IDLE;
                    load_ready_q <= 1'b0;
                    load_done_q  <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.lut_out    = lut_out_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.load_ready = load_ready_q;
    assign bus.load_done  = load_done_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_lut_calc_multi.sv
// Self-checking bench for lut_calc_multi: table vectors, scoreboarded lookups, load/abort/reset sequences.
// Latency: expects results two edges after the sampling edge.
// Backpressure: writes are only driven while the load FSM is expected to be in LOAD.
module tb_lut_calc_multi;
    localparam int NCH   = 4;
    localparam int AW    = 4;
    localparam int DW    = 28;
    localparam int OW    = 21;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lut_calc_multi_if #(.NCH(NCH), .AW(AW), .DW(DW), .OW(OW)) bus ();

    lut_calc_multi #(.NCH(NCH), .AW(AW), .DW(DW), .OW(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int            ch;
        logic [OW-1:0] exp;
        int            cyc;
    } sb_t;

    typedef struct {
        int            addr;
        bit            sat;
        int            ch;
        logic [OW-1:0] exp;
    } vec_t;

    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            done_cnt = 0;
    int            done_saved = 0;
    int            cur_ch = 0;
    int            wptr = 0;
    sb_t           sb [$];
    logic [DW-1:0] model [NCH][DEPTH];
    logic [NCH*OW-1:0] last_out = '0;
    vec_t          vecs [17];
    logic [DW-1:0] w0 [DEPTH];

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference conversion written as numeric comparisons against the OW range.
    function automatic logic [OW-1:0] ref_conv(input logic [DW-1:0] w, input bit sat);
        longint     v;
        longint     mx;
        longint     mn;
        logic [63:0] t;
        v  = longint'($signed(w));
        mx = (longint'(1) <<< (OW-1)) - 1;
        mn = -(longint'(1) <<< (OW-1));
        if (sat && v > mx)      t = 64'(mx);
        else if (sat && v < mn) t = 64'(mn);
        else                    t = 64'(v);
        return t[OW-1:0];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pops the scoreboard on out_valid, checks timing, and checks hold when idle.
    always @(negedge clk) begin
        sb_t e;
        logic [OW-1:0] slice;
        if (rst) begin
            last_out = '0;
        end else begin
            if (bus.load_done) done_cnt++;
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 128'(1), 128'(0));
                end else begin
                    e = sb.pop_front();
                    slice = bus.lut_out[e.ch*OW +: OW];
                    check("result_cycle", 128'(cyc), 128'(e.cyc));
                    check("result_data", 128'(slice), 128'(e.exp));
                end
                last_out = bus.lut_out;
            end else begin
                check("lut_out_hold", 128'(bus.lut_out), 128'(last_out));
                if (sb.size() > 0 && sb[0].cyc < cyc) begin
                    check("missing_out_valid", 128'(0), 128'(1));
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic lookup_exp(input int a, input bit s, input int ch, input logic [OW-1:0] exp);
        sb_t e;
        bus.addr_in    = AW'(a);
        bus.addr_valid = 1'b1;
        bus.sat_en     = s;
        e.ch  = ch;
        e.exp = exp;
        e.cyc = cyc + 3;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.addr_valid = 1'b0;
    endtask

    task automatic lookup(input int a, input bit s, input int ch);
        lookup_exp(a, s, ch, ref_conv(model[ch][a], s));
    endtask

    task automatic drain();
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("scoreboard_empty", 128'(sb.size()), 128'(0));
    endtask

    task automatic start_load(input int ch);
        done_saved      = done_cnt;
        bus.load_start  = 1'b1;
        bus.load_ch     = 2'(ch);
        @(posedge clk); #1;
        bus.load_start  = 1'b0;
        cur_ch = ch;
        wptr   = 0;
        check("load_ready_in_load", 128'(bus.load_ready), 128'(1));
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        bus.load_valid = 1'b1;
        bus.load_data  = d;
        @(posedge clk); #1;
        bus.load_valid = 1'b0;
        model[cur_ch][wptr] = d;
        wptr++;
    endtask

    task automatic finish_check();
        check("load_done_pulse", 128'(bus.load_done), 128'(1));
        check("load_ready_in_done", 128'(bus.load_ready), 128'(0));
        check("busy_in_done", 128'(bus.busy), 128'(1));
        @(posedge clk); #1;
        check("load_done_clear", 128'(bus.load_done), 128'(0));
        check("busy_after_done", 128'(bus.busy), 128'(0));
        check("load_done_count", 128'(done_cnt), 128'(done_saved + 1));
    endtask

    task automatic abort_load();
        bus.load_abort = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_data  = 28'h5555555;
        @(posedge clk); #1;
        bus.load_abort = 1'b0;
        bus.load_valid = 1'b0;
        check("busy_after_abort", 128'(bus.busy), 128'(0));
        check("ready_after_abort", 128'(bus.load_ready), 128'(0));
        check("no_done_on_abort", 128'(done_cnt), 128'(done_saved));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        // Channel 0 words exercising the saturation boundaries.
        w0[0] = 28'd0;         w0[1] = 28'd12345;     w0[2] = 28'hFFFFFF9;   w0[3] = 28'h0200000;
        w0[4] = 28'hFE00000;   w0[5] = 28'h00FFFFF;   w0[6] = 28'hFF00000;   w0[7] = 28'h7FFFFFF;
        w0[8] = 28'h8000000;   w0[9] = 28'h0100000;   w0[10] = 28'hFEFFFFF;
        for (int i = 11; i < DEPTH; i++) w0[i] = DW'(i);

        vecs[0]  = '{3, 1'b1, 0, 21'h0FFFFF};
        vecs[1]  = '{3, 1'b0, 0, 21'h000000};
        vecs[2]  = '{4, 1'b1, 0, 21'h100000};
        vecs[3]  = '{4, 1'b0, 0, 21'h000000};
        vecs[4]  = '{5, 1'b1, 0, 21'h0FFFFF};
        vecs[5]  = '{6, 1'b1, 0, 21'h100000};
        vecs[6]  = '{7, 1'b1, 0, 21'h0FFFFF};
        vecs[7]  = '{7, 1'b0, 0, 21'h1FFFFF};
        vecs[8]  = '{8, 1'b1, 0, 21'h100000};
        vecs[9]  = '{8, 1'b0, 0, 21'h000000};
        vecs[10] = '{9, 1'b1, 0, 21'h0FFFFF};
        vecs[11] = '{9, 1'b0, 0, 21'h100000};
        vecs[12] = '{10, 1'b1, 0, 21'h100000};
        vecs[13] = '{10, 1'b0, 0, 21'h0FFFFF};
        vecs[14] = '{2, 1'b1, 0, 21'h1FFFF9};
        vecs[15] = '{1, 1'b0, 0, 21'h003039};
        vecs[16] = '{5, 1'b1, 1, 21'h001388};

        bus.addr_in    = '0;
        bus.addr_valid = 1'b0;
        bus.sat_en     = 1'b0;
        bus.load_start = 1'b0;
        bus.load_ch    = '0;
        bus.load_data  = '0;
        bus.load_valid = 1'b0;
        bus.load_abort = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_lut_out", 128'(bus.lut_out), 128'(0));
        check("rst_busy", 128'(bus.busy), 128'(0));
        check("rst_load_ready", 128'(bus.load_ready), 128'(0));
        check("rst_load_done", 128'(bus.load_done), 128'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Fill all four channels; channel 2 has valid gaps and ignored load_start pulses.
        start_load(0);
        for (int i = 0; i < DEPTH; i++) write_word(w0[i]);
        finish_check();
        start_load(1);
        for (int i = 0; i < DEPTH; i++) write_word(DW'(i * 1000));
        finish_check();
        start_load(2);
        for (int i = 0; i < DEPTH; i++) begin
            if (i % 5 == 4) begin
                bus.load_start = 1'b1;
                bus.load_ch    = 2'd3;
                @(posedge clk); #1;
                bus.load_start = 1'b0;
                check("ready_during_gap", 128'(bus.load_ready), 128'(1));
            end
            write_word(DW'(-(i * 777)));
        end
        finish_check();
        start_load(3);
        for (int i = 0; i < DEPTH; i++) write_word(DW'(i) << 22);
        finish_check();

        // Table vectors, issued back to back.
        for (int i = 0; i < 17; i++) lookup_exp(vecs[i].addr, vecs[i].sat, vecs[i].ch, vecs[i].exp);
        drain();

        // Consecutive lookups, then a gap during which lut_out must hold.
        for (int a = 0; a < 4; a++) lookup(a, 1'b0, 1);
        repeat (2) begin
            @(posedge clk); #1;
        end
        lookup(4, 1'b0, 1);
        drain();

        // Assorted lookups across channels and modes.
        for (int i = 0; i < 12; i++)
            lookup(int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        drain();

        // Abort after seven writes: only addresses 0..6 change.
        start_load(1);
        for (int i = 0; i < 7; i++) write_word(DW'(77 + i));
        abort_load();
        for (int a = 0; a < DEPTH; a++) lookup(a, 1'b0, 1);
        drain();

        // Same-cycle read/write returns the old word; the following read sees the new word.
        start_load(2);
        write_word(DW'(111));
        write_word(DW'(222));
        bus.load_valid = 1'b1;
        bus.load_data  = DW'(333);
        lookup(2, 1'b0, 2);
        model[2][2] = DW'(333);
        bus.load_data = DW'(444);
        lookup(2, 1'b0, 2);
        model[2][3] = DW'(444);
        bus.load_valid = 1'b0;
        lookup(5, 1'b1, 0);
        lookup(3, 1'b0, 2);
        abort_load();
        drain();

        // Reset mid-load with a lookup in flight; restart immediately after release.
        start_load(3);
        for (int i = 0; i < 3; i++) write_word(DW'(28'hABC + i));
        bus.addr_in    = AW'(1);
        bus.addr_valid = 1'b1;
        @(posedge clk); #1;
        bus.addr_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_busy", 128'(bus.busy), 128'(0));
        check("midrst_out_valid", 128'(bus.out_valid), 128'(0));
        check("midrst_lut_out", 128'(bus.lut_out), 128'(0));
        check("midrst_load_ready", 128'(bus.load_ready), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_no_done", 128'(done_cnt), 128'(done_saved));
        start_load(2);
        check("restart_busy", 128'(bus.busy), 128'(1));
        for (int i = 0; i < DEPTH; i++) write_word(DW'(28'h5A5A00 + i));
        finish_check();
        for (int a = 0; a < 4; a++) lookup(a, 1'b1, 3);
        for (int a = 0; a < 4; a++) lookup(a, 1'b0, 2);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
